fltc_latent_seq: RTL and testbench

Latent-fault test sequencer for the fault-tolerant checker (fltc) comparator tree. On `start` it walks a one-hot error injection across every bit of the functional path, then every bit of the check path, and confirms that the matching checker error output (`cerr_func` / `cerr_check`) fires and then clears. Any missed or stuck detection sets the sticky `latent_fault_tree` flag and records the failing bit. It sits beside the fltc checker and drives its `latent_error_func` / `latent_error_check` inputs.

---
 rtl/fltc_pkg.sv | 24 ++
 rtl/fltc_onehot_dec.sv | 18 +
 rtl/fltc_latent_seq.sv | 184 ++++++++++++++++++
 tb/tb_fltc_latent_seq.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fltc_pkg.sv
// Shared types and constants for the fltc latent-fault test sequencer.
// Holds the sequencer state and side encodings plus the failure-counter width.
package fltc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RECOVER = 2'd2,
        DONE    = 2'd3
    } fltc_seq_state_e;

    typedef enum logic {
        FUNC  = 1'b0,
        CHECK = 1'b1
    } fltc_side_e;

    localparam int FLTC_ERRCNT_W = 16;

    // Failure counter sticks at all-ones instead of wrapping back to zero.
    function automatic logic [FLTC_ERRCNT_W-1:0] fltc_sat_inc(input logic [FLTC_ERRCNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fltc_onehot_dec.sv
// Index-to-one-hot decoder feeding the injection registers; purely combinational.
// All-zero output when not enabled.
module fltc_onehot_dec #(
    parameter int WIDTH = 1024
) (
    input  logic                     en,
    input  logic [$clog2(WIDTH)-1:0] idx,
    output logic [WIDTH-1:0]         vec
);

    always_comb begin
        vec = '0;
        if (en) begin
            vec[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fltc_latent_seq.sv
// Latent-fault sequencer: walks a one-hot injection over the func then check path and checks each detection fires then clears.
// Injection is registered (visible the cycle after the deciding edge); no backpressure, each phase waits at most LAT cycles.
module fltc_latent_seq
    import fltc_pkg::*;
#(
    parameter int WIDTH = 1024,
    parameter int LAT   = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     cerr_func,
    input  logic                     cerr_check,
    output logic [WIDTH-1:0]         latent_error_func,
    output logic [WIDTH-1:0]         latent_error_check,
    output logic                     busy,
    output logic                     done,
    output logic                     latent_fault_tree,
    output logic [$clog2(WIDTH)-1:0] fail_idx,
    output logic                     fail_side,
    output logic                     fail_stuck,
    output logic [FLTC_ERRCNT_W-1:0] err_cnt
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int CNT_W = $clog2(LAT + 1);

    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_WAIT    = WAIT;
    localparam logic [1:0] S_RECOVER = RECOVER;
    localparam logic [1:0] S_DONE    = DONE;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT - 1);

    logic [1:0]               state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    fltc_side_e               side_q, side_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [FLTC_ERRCNT_W-1:0] err_cnt_q;

    logic             exp_err;
    logic             advance;
    logic             fail_ev;
    logic             stuck_ev;
    logic             clr_flags;
    logic             inj_en;
    logic [WIDTH-1:0] dec_vec;

    assign exp_err = (side_q == CHECK) ? cerr_check : cerr_func;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        side_d    = side_q;
        cnt_d     = cnt_q;
        advance   = 1'b0;
        fail_ev   = 1'b0;
        stuck_ev  = 1'b0;
        clr_flags = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_WAIT;
                    idx_d     = '0;
                    side_d    = FUNC;
                    cnt_d     = '0;
                    clr_flags = 1'b1;
                end
            end
            S_WAIT: begin
                // Only the injected side counts; the other checker output is ignored here.
                if (exp_err) begin
                    state_d = S_RECOVER;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    fail_ev = 1'b1;
                    state_d = S_RECOVER;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RECOVER: begin
                if (!(cerr_func | cerr_check)) begin
                    advance = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    fail_ev  = 1'b1;
                    stuck_ev = 1'b1;
                    advance  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (advance) begin
            cnt_d = '0;
            if (idx_q != IDX_LAST) begin
                idx_d   = idx_q + 1'b1;
                state_d = S_WAIT;
            end else if (side_q == FUNC) begin
                idx_d   = '0;
                side_d  = CHECK;
                state_d = S_WAIT;
            end else begin
                state_d = S_DONE;
            end
        end
    end

    // The injection vector is a pure function of the next state, so it holds through WAIT
    // and drops to zero on the same edge that leaves it.
    assign inj_en = (state_d == S_WAIT);

    fltc_onehot_dec #(
        .WIDTH (WIDTH)
    ) u_dec (
        .en  (inj_en),
        .idx (idx_d),
        .vec (dec_vec)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q            <= S_IDLE;
            idx_q              <= '0;
            side_q             <= FUNC;
            cnt_q              <= '0;
            latent_error_func  <= '0;
            latent_error_check <= '0;
        end else begin
            state_q            <= state_d;
            idx_q              <= idx_d;
            side_q             <= side_d;
            cnt_q              <= cnt_d;
            latent_error_func  <= (side_d == FUNC)  ? dec_vec : '0;
            latent_error_check <= (side_d == CHECK) ? dec_vec : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            latent_fault_tree <= 1'b0;
            err_cnt_q         <= '0;
            fail_idx          <= '0;
            fail_side         <= 1'b0;
            fail_stuck        <= 1'b0;
        end else if (clr_flags) begin
            latent_fault_tree <= 1'b0;
            err_cnt_q         <= '0;
            fail_idx          <= '0;
            fail_side         <= 1'b0;
            fail_stuck        <= 1'b0;
        end else if (fail_ev) begin
            latent_fault_tree <= 1'b1;
            err_cnt_q         <= fltc_sat_inc(err_cnt_q);
            // Only the first failure of a sweep is kept for diagnosis.
            if (err_cnt_q == '0) begin
                fail_idx   <= idx_q;
                fail_side  <= side_q;
                fail_stuck <= stuck_ev;
            end
        end
    end

    assign err_cnt = err_cnt_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);

    a_single_injection: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0({latent_error_func, latent_error_check}));

    a_done_while_busy: assert property (@(posedge clk) disable iff (!reset_n)
        done |-> busy);

endmodule

// File: tb/tb_fltc_latent_seq.sv
module tb_fltc_latent_seq;

    localparam int W   = 8;
    localparam int L   = 4;
    localparam int NB  = 2 * W;
    localparam int BW  = 1024;
    localparam int BL  = 2;
    localparam int INF = 1000;

    typedef struct packed {
        logic [W-1:0] f;
        logic [W-1:0] c;
        logic         busy;
        logic         done;
        logic         ltf;
        logic [2:0]   idx;
        logic         side;
        logic         stuck;
        logic [15:0]  cnt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic         start;
    logic         cerr_func;
    logic         cerr_check;
    logic [W-1:0] lef;
    logic [W-1:0] lec;
    logic         busy;
    logic         done;
    logic         ltf;
    logic [2:0]   fidx;
    logic         fside;
    logic         fstuck;
    logic [15:0]  ecnt;

    logic          start_b;
    logic [BW-1:0] lef_b;
    logic [BW-1:0] lec_b;
    logic          busy_b;
    logic          done_b;
    logic          ltf_b;
    logic [9:0]    fidx_b;
    logic          fside_b;
    logic          fstuck_b;
    logic [15:0]   ecnt_b;

    fltc_latent_seq #(.WIDTH(W), .LAT(L)) u_dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .start              (start),
        .cerr_func          (cerr_func),
        .cerr_check         (cerr_check),
        .latent_error_func  (lef),
        .latent_error_check (lec),
        .busy               (busy),
        .done               (done),
        .latent_fault_tree  (ltf),
        .fail_idx           (fidx),
        .fail_side          (fside),
        .fail_stuck         (fstuck),
        .err_cnt            (ecnt)
    );

    // Large instance whose checker never responds: every bit is a detection failure.
    fltc_latent_seq #(.WIDTH(BW), .LAT(BL)) u_big (
        .clk                (clk),
        .reset_n            (reset_n),
        .start              (start_b),
        .cerr_func          (1'b0),
        .cerr_check         (1'b0),
        .latent_error_func  (lef_b),
        .latent_error_check (lec_b),
        .busy               (busy_b),
        .done               (done_b),
        .latent_fault_tree  (ltf_b),
        .fail_idx           (fidx_b),
        .fail_side          (fside_b),
        .fail_stuck         (fstuck_b),
        .err_cnt            (ecnt_b)
    );

    // Per-bit responder profile: checker error rises s cycles after the injection is
    // visible (s >= L never within the window) and stays high t cycles after it drops.
    int   s_arr [NB];
    int   t_arr [NB];
    exp_t exp_q [$];
    int   done_idx;
    int   n_cmp  = 0;
    int   n_fail = 0;

    bit resp_en = 1'b0;
    bit in_inj, in_rec, rside, hit;
    int rk, age;

    always @(negedge clk) begin
        if (!resp_en) begin
            in_inj = 1'b0; in_rec = 1'b0; rk = -1; age = 0;
            cerr_func = 1'b0; cerr_check = 1'b0;
        end else if (lef != '0 || lec != '0) begin
            if (!in_inj) begin
                in_inj = 1'b1; in_rec = 1'b0; age = 0;
                if (rk < NB - 1) rk++;
                rside = (lec != '0);
            end else begin
                age++;
            end
            hit = (age >= s_arr[rk]);
            // Opposite side gets random noise to show it is ignored while waiting.
            if (rside) begin
                cerr_check = hit; cerr_func = 1'($urandom_range(0, 1));
            end else begin
                cerr_func = hit; cerr_check = 1'($urandom_range(0, 1));
            end
        end else if (in_inj || in_rec) begin
            if (in_inj) begin
                in_inj = 1'b0; in_rec = 1'b1; age = 0;
            end else begin
                age++;
            end
            hit = (age < t_arr[rk]);
            cerr_func  = !rside && hit;
            cerr_check = rside && hit;
        end else begin
            cerr_func = 1'b0; cerr_check = 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic void set_ideal();
        for (int k = 0; k < NB; k++) begin
            s_arr[k] = 1;
            t_arr[k] = 1;
        end
    endfunction

    function automatic void record(inout exp_t e, input int idx, input int side, input bit stuck);
        if (e.cnt == 16'd0) begin
            e.idx   = 3'(idx);
            e.side  = side[0];
            e.stuck = stuck;
        end
        e.ltf = 1'b1;
        if (e.cnt != 16'hFFFF) e.cnt = e.cnt + 16'd1;
    endfunction

    // Expected per-cycle outputs, cycle 0 being the one right after the start edge.
    function automatic void build_exp();
        exp_t e;
        int   w, r, side, idx;
        e = '0;
        e.busy = 1'b1;
        exp_q.delete();
        for (int k = 0; k < NB; k++) begin
            side = k / W;
            idx  = k % W;
            w = (s_arr[k] < L) ? s_arr[k] + 1 : L;
            r = (t_arr[k] < L) ? t_arr[k] + 1 : L;
            e.f = (side == 0) ? (W'(1) << idx) : '0;
            e.c = (side == 1) ? (W'(1) << idx) : '0;
            for (int j = 0; j < w; j++) exp_q.push_back(e);
            e.f = '0;
            e.c = '0;
            if (s_arr[k] >= L) record(e, idx, side, 1'b0);
            for (int j = 0; j < r; j++) exp_q.push_back(e);
            if (t_arr[k] >= L) record(e, idx, side, 1'b1);
        end
        done_idx = exp_q.size();
        e.done = 1'b1;
        exp_q.push_back(e);
        e.done = 1'b0;
        e.busy = 1'b0;
        exp_q.push_back(e);
        exp_q.push_back(e);
    endfunction

    task automatic run_sweep(input bit pulse, input int stop_at, output int ndone);
        exp_t act;
        ndone = 0;
        build_exp();
        resp_en = 1'b0;
        repeat (2) @(negedge clk);
        start   = 1'b1;
        resp_en = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            #1;
            act = {lef, lec, busy, done, ltf, fidx, fside, fstuck, ecnt};
            chk($sformatf("cyc%0d", i), 64'(act), 64'(exp_q[i]));
            if (done) ndone++;
            if (i == stop_at) break;
            if (pulse && (i == 20 || i == done_idx)) start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
    endtask

    int nd;
    int guard;

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        start_b = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_vec", {lef, lec}, '0);
        chk("rst_flags", {busy, done, ltf, fside, fstuck}, '0);
        chk("rst_cnt", {fidx, ecnt}, '0);
        @(negedge clk);
        reset_n = 1'b1;

        // Ideal registered responder: 4 cycles per bit.
        set_ideal();
        run_sweep(1'b0, -1, nd);
        chk("ideal_done_cycle", done_idx, 64);
        chk("ideal_done_count", nd, 1);
        chk("ideal_clean", {ltf, ecnt}, '0);

        // Func bit 5 never detected.
        set_ideal();
        s_arr[5] = INF;
        t_arr[5] = 0;
        run_sweep(1'b0, -1, nd);
        chk("mask_done_count", nd, 1);
        chk("mask_ltf", ltf, 1);
        chk("mask_fail_idx", fidx, 5);
        chk("mask_fail_side", fside, 0);
        chk("mask_fail_stuck", fstuck, 0);
        chk("mask_err_cnt", ecnt, 1);

        // Check error stuck high from check bit 2 to the end.
        set_ideal();
        t_arr[W + 2] = INF;
        for (int k = W + 3; k < NB; k++) begin
            s_arr[k] = 0;
            t_arr[k] = INF;
        end
        run_sweep(1'b0, -1, nd);
        chk("stuck_fail_idx", fidx, 2);
        chk("stuck_fail_side", fside, 1);
        chk("stuck_fail_stuck", fstuck, 1);
        chk("stuck_err_cnt", ecnt, 6);

        // Start while busy and in the DONE cycle must be ignored.
        set_ideal();
        run_sweep(1'b1, -1, nd);
        chk("ign_done_count", nd, 1);
        chk("ign_len", done_idx, 64);

        // Reset while check bit 3 is injected.
        set_ideal();
        run_sweep(1'b0, 44, nd);
        chk("prerst_check_vec", lec, 8'h08);
        reset_n = 1'b0;
        #1;
        chk("midrst_vec", {lef, lec}, '0);
        chk("midrst_busy_done", {busy, done}, '0);
        resp_en = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("midrst_no_done", {done, busy}, '0);
        end
        reset_n = 1'b1;
        set_ideal();
        run_sweep(1'b0, -1, nd);
        chk("postrst_done_count", nd, 1);

        // Randomised checker latencies, including misses and stuck errors.
        repeat (4) begin
            for (int k = 0; k < NB; k++) begin
                s_arr[k] = $urandom_range(0, L + 1);
                t_arr[k] = $urandom_range(0, L + 1);
            end
            run_sweep(1'b0, -1, nd);
            chk("rand_done_count", nd, 1);
        end

        // Large instance: every bit fails; counter preloaded near the top must saturate.
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        #1 start_b = 1'b0;
        guard = 0;
        while (ecnt_b == 16'd0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("big_first_fail", ecnt_b, 1);
        force u_big.err_cnt_q = 16'hFFFC;
        repeat (4) @(negedge clk);
        release u_big.err_cnt_q;
        guard = 0;
        while (!done_b && guard < 10000) begin
            @(negedge clk);
            guard++;
        end
        chk("big_done_seen", done_b, 1);
        chk("big_err_sat", ecnt_b, 16'hFFFF);
        chk("big_ltf", ltf_b, 1);
        chk("big_first_rec", {fidx_b, fside_b, fstuck_b}, '0);
        @(negedge clk);
        chk("big_idle", {busy_b, done_b, lef_b != '0, lec_b != '0}, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
